maze_render_scheduler: RTL and testbench
========================================

// Module: maze_render_scheduler
// PURPOSE
//  Sequences a full-screen raster redraw of the generated maze onto the LT24 pixel port.
//  Sits between Maze_Maker (maze bit vector, gen_end) and LT24Display (xAddr/yAddr/pixelData/pixelWrite/pixelReady).
//  Maps each maze cell to a TILE x TILE pixel block and colours it wall/path/background.
//  Owns the pixel port: LT24Display pixelWrite is driven from here, never tied high.
// PARAMETERS
//  SCREEN_W     240       display width in pixels
//  SCREEN_H     320       display height in pixels
//  MAZE_W       30        maze width in cells
//  MAZE_H       10        maze height in cells
//  TILE_LOG2    3         log2 of tile edge; TILE = 8 pixels
//  WALL_COLOUR  16'h0000  RGB565 for maze bit = 1
//  PATH_COLOUR  16'h07E0  RGB565 for maze bit = 0
//  BG_COLOUR    16'h001F  RGB565 for pixels outside the maze area
//  GRID_COLOUR  16'h8410  RGB565 tile grid lines (MAZE_RENDER_GRID_EN only)
// PORTS
//  clock        in   1              system clock, 50 MHz
//  globalReset  in   1              asynchronous, active-high reset
//  start        in   1              single-cycle request to redraw one frame
//  mazeValid    in   1              level; Maze_Maker gen_end
//  maze         in   MAZE_W*MAZE_H  cell bits; index = row*MAZE_W + col; 1 = wall
//  pixelReady   in   1              LT24Display can accept a pixel this cycle
//  xAddr        out  8              pixel column
//  yAddr        out  9              pixel row
//  pixelData    out  16             RGB565 pixel value
//  pixelWrite   out  1              pixel valid
//  busy         out  1              high in WAIT_MAZE or DRAW
//  frameDone    out  1              one-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  Reset: state = IDLE; xAddr = 0, yAddr = 0, pixelData = 0; pixelWrite, busy, frameDone = 0.
//  All outputs registered. A pixel is accepted on a rising edge with pixelWrite && pixelReady.
//  States:
//   IDLE: start -> WAIT_MAZE.
//   WAIT_MAZE: mazeValid = 1 -> DRAW, with x,y = 0,0 and pixelWrite = 1 on the first DRAW cycle.
//    start and mazeValid high together in IDLE still pass through WAIT_MAZE: 2 cycles from start to the first pixelWrite.
//   DRAW: raster order, x fastest (0..SCREEN_W-1), then y.
//    On accept, advance x; at x = SCREEN_W-1, wrap x to 0 and increment y.
//    Accept at (SCREEN_W-1, SCREEN_H-1) -> DONE, pixelWrite = 0.
//   DONE: frameDone = 1 for exactly 1 cycle -> IDLE.
//  Stall: while pixelReady = 0, xAddr, yAddr, pixelData and pixelWrite hold their values.
//  Colour, computed for the next pixel and registered with its address:
//   col = x >> TILE_LOG2, row = y >> TILE_LOG2.
//   col >= MAZE_W or row >= MAZE_H -> BG_COLOUR; else maze[row*MAZE_W+col] ? WALL_COLOUR : PATH_COLOUR.
//   Cell index width: clog2(MAZE_W*MAZE_H), 9 bits at defaults; no wrap allowed.
//  start while busy: ignored, not queued.
//  mazeValid falls during DRAW (regeneration): on the next edge pixelWrite = 0, x,y = 0,0 -> WAIT_MAZE.
//   The frame restarts from pixel (0,0); frameDone is not pulsed.
//  globalReset mid-frame: immediate return to reset values; no partial frameDone.
// CONFIGURATION
//  MAZE_RENDER_GRID_EN defined: pixels with (x & (TILE-1)) == TILE-1 or (y & (TILE-1)) == TILE-1, inside the maze area, take GRID_COLOUR.
//   Grid overrides wall/path colour. Timing is unchanged.
//  MAZE_RENDER_GRID_EN undefined: no grid logic; tiles are solid colour.
// TESTING
//  1 Reset, then idle 10 cycles -> all outputs 0, busy = 0.
//  2 maze all 0, mazeValid = 1, pixelReady = 1, start pulse -> pixelWrite 2 cycles later;
//    (0,0) = 16'h07E0; (0,80) = 16'h001F.
//  3 maze[0] = 1, others 0 -> (0..7, 0..7) = 16'h0000; (8,0) and (0,8) = 16'h07E0.
//  4 pixelReady toggled 1-of-3 cycles -> 76800 accepts, no address skip/repeat; frameDone once, 1 cycle after (239,319).
//  5 mazeValid dropped at pixel (100,40), raised 5 cycles later -> restart at (0,0); no frameDone until the full frame completes.
//  6 MAZE_RENDER_GRID_EN defined, maze all 0 -> (7,0) = 16'h8410, (6,6) = 16'h07E0, (7,100) = 16'h001F.

Source files
------------

// File: rtl/maze_render_scheduler.sv
// Raster redraw sequencer: walks every LT24 pixel, colours it from the maze cell under it, and drives the pixel port.
// Optional tile grid overlay is enabled by defining MAZE_RENDER_GRID_EN.
module maze_render_scheduler #(
  parameter int          SCREEN_W    = 240,
  parameter int          SCREEN_H    = 320,
  parameter int          MAZE_W      = 30,
  parameter int          MAZE_H      = 10,
  parameter int          TILE_LOG2   = 3,
  parameter logic [15:0] WALL_COLOUR = 16'h0000,
  parameter logic [15:0] PATH_COLOUR = 16'h07E0,
`ifdef MAZE_RENDER_GRID_EN
  parameter logic [15:0] GRID_COLOUR = 16'h8410,
`endif
  parameter logic [15:0] BG_COLOUR   = 16'h001F
) (
  input  logic                       clock,
  input  logic                       globalReset,
  input  logic                       start,
  input  logic                       mazeValid,
  input  logic [MAZE_W*MAZE_H-1:0]   maze,
  input  logic                       pixelReady,
  output logic [7:0]                 xAddr,
  output logic [8:0]                 yAddr,
  output logic [15:0]                pixelData,
  output logic                       pixelWrite,
  output logic                       busy,
  output logic                       frameDone
);

  localparam int CELLS = MAZE_W * MAZE_H;
  localparam int IDX_W = $clog2(CELLS);

  typedef enum logic [1:0] {IDLE, WAIT_MAZE, DRAW, DONE} state_t;
  state_t state;

  logic       last_x;
  logic       last_px;
  logic [7:0] next_x;
  logic [8:0] next_y;

  // Colour of a pixel; the cell index is only formed inside the maze area so it never wraps.
  function automatic logic [15:0] colour_of(input logic [7:0] x, input logic [8:0] y);
    int               col;
    int               row;
    logic [IDX_W-1:0] idx;
    col       = int'(x >> TILE_LOG2);
    row       = int'(y >> TILE_LOG2);
    idx       = '0;
    colour_of = BG_COLOUR;
    if (col < MAZE_W && row < MAZE_H) begin
      idx       = IDX_W'(row * MAZE_W + col);
      colour_of = maze[idx] ? WALL_COLOUR : PATH_COLOUR;
`ifdef MAZE_RENDER_GRID_EN
      if (&x[TILE_LOG2-1:0] || &y[TILE_LOG2-1:0]) colour_of = GRID_COLOUR;
`endif
    end
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    last_x  = (int'(xAddr) == SCREEN_W - 1);
    last_px = last_x && (int'(yAddr) == SCREEN_H - 1);
    next_x  = last_x ? 8'd0 : xAddr + 8'd1;
    next_y  = last_x ? yAddr + 9'd1 : yAddr;
  end

  // NOTE: state and registered outputs use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clock or posedge globalReset) begin
    if (globalReset) begin
      state      <= IDLE;
      xAddr      <= '0;
      yAddr      <= '0;
      pixelData  <= '0;
      pixelWrite <= 1'b0;
      busy       <= 1'b0;
      frameDone  <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_MAZE;
            busy  <= 1'b1;
          end
        end
        WAIT_MAZE: begin
          if (mazeValid) begin
            state      <= DRAW;
            xAddr      <= '0;
            yAddr      <= '0;
            pixelData  <= colour_of(8'd0, 9'd0);
            pixelWrite <= 1'b1;
          end
        end
        DRAW: begin
          // Maze regeneration aborts the frame; it restarts from the origin once the maze is valid again.
          if (!mazeValid) begin
            state      <= WAIT_MAZE;
            pixelWrite <= 1'b0;
            xAddr      <= '0;
            yAddr      <= '0;
          end else if (pixelReady) begin
            if (last_px) begin
              state      <= DONE;
              pixelWrite <= 1'b0;
              busy       <= 1'b0;
              frameDone  <= 1'b1;
            end else begin
              xAddr     <= next_x;
              yAddr     <= next_y;
              pixelData <= colour_of(next_x, next_y);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_render_scheduler.sv
// Scoreboard bench for maze_render_scheduler on a reduced 40x104 screen and 4x10 maze.
// Expected pixels are queued from an independent colour model and popped on every accepted pixel.
module tb_maze_render_scheduler;

  localparam int SW   = 40;
  localparam int SH   = 104;
  localparam int MW   = 4;
  localparam int MH   = 10;
  localparam int MB   = MW * MH;
  localparam int NPIX = SW * SH;

  typedef struct packed {
    logic [7:0]  x;
    logic [8:0]  y;
    logic [15:0] d;
  } pix_t;

  logic          clock = 1'b0;
  logic          globalReset;
  logic          start;
  logic          mazeValid;
  logic [MB-1:0] maze;
  logic          pixelReady;
  logic [7:0]    xAddr;
  logic [8:0]    yAddr;
  logic [15:0]   pixelData;
  logic          pixelWrite;
  logic          busy;
  logic          frameDone;

  int   errors  = 0;
  int   checks  = 0;
  int   accepts = 0;
  pix_t sb[$];
  pix_t spots[$];

  maze_render_scheduler #(
    .SCREEN_W(SW), .SCREEN_H(SH), .MAZE_W(MW), .MAZE_H(MH), .TILE_LOG2(3)
  ) dut (
    .clock(clock), .globalReset(globalReset), .start(start), .mazeValid(mazeValid),
    .maze(maze), .pixelReady(pixelReady), .xAddr(xAddr), .yAddr(yAddr),
    .pixelData(pixelData), .pixelWrite(pixelWrite), .busy(busy), .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_colour(input int x, input int y, input logic [MB-1:0] m);
    int col = x / 8;
    int row = y / 8;
    if (col >= MW || row >= MH) return 16'h001F;
`ifdef MAZE_RENDER_GRID_EN
    if ((x % 8) == 7 || (y % 8) == 7) return 16'h8410;
`endif
    return m[row * MW + col] ? 16'h0000 : 16'h07E0;
  endfunction

  task automatic push_frame();
    sb.delete();
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        sb.push_back('{8'(x), 9'(y), exp_colour(x, y, maze)});
  endtask

  task automatic add_spot(input int x, input int y, input logic [15:0] d);
    spots.push_back('{8'(x), 9'(y), d});
  endtask

  // One clock: score the pixel presented this cycle, then step past the edge.
  task automatic cycle();
    pix_t got;
    pix_t exp;
    logic popped_last;
    popped_last = 1'b0;
    if (pixelWrite && pixelReady) begin
      got = '{xAddr, yAddr, pixelData};
      exp = (sb.size() > 0) ? sb.pop_front() : '1;
      popped_last = (exp != '1) && (sb.size() == 0);
      check("pixel", 64'(got), 64'(exp));
      accepts++;
      if (spots.size() > 0 && spots[0].x == got.x && spots[0].y == got.y) begin
        check("spot_colour", 64'(got.d), 64'(spots[0].d));
        void'(spots.pop_front());
      end
    end
    @(posedge clock);
    #1;
    check("frameDone", 64'(frameDone), 64'(popped_last));
  endtask

  task automatic start_frame();
    push_frame();
    accepts = 0;
    start   = 1'b1;
    cycle();
    start   = 1'b0;
  endtask

  task automatic run_frame(input int budget, input bit third);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < budget) begin
      pixelReady = third ? (n % 3 == 0) : 1'b1;
      start      = (n == 100);
      cycle();
      start      = 1'b0;
      n++;
      if (frameDone) seen = 1'b1;
    end
    check("frame_done_seen", 64'(seen), 64'd1);
    check("accept_count", 64'(accepts), 64'(NPIX));
    check("sb_drained", 64'(sb.size()), 64'd0);
    check("spots_hit", 64'(spots.size()), 64'd0);
    pixelReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_write", 64'(pixelWrite), 64'd0);
    end
  endtask

  initial begin
    int n;
    globalReset = 1'b1;
    start       = 1'b0;
    mazeValid   = 1'b0;
    pixelReady  = 1'b0;
    maze        = '0;
    #12 globalReset = 1'b0;

    // Reset then idle.
    for (int i = 0; i < 10; i++) cycle();
    check("rst_x", 64'(xAddr), 64'd0);
    check("rst_y", 64'(yAddr), 64'd0);
    check("rst_data", 64'(pixelData), 64'd0);
    check("rst_write", 64'(pixelWrite), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(frameDone), 64'd0);

    // Empty maze: first write two cycles after start; path at origin, background below the maze.
    maze       = '0;
    mazeValid  = 1'b1;
    pixelReady = 1'b1;
    add_spot(0, 0, 16'h07E0);
`ifdef MAZE_RENDER_GRID_EN
    add_spot(7, 0, 16'h8410);
    add_spot(6, 6, 16'h07E0);
`endif
    add_spot(0, 80, 16'h001F);
`ifdef MAZE_RENDER_GRID_EN
    add_spot(7, 100, 16'h001F);
`endif
    start_frame();
    check("wait_busy", 64'(busy), 64'd1);
    check("wait_write", 64'(pixelWrite), 64'd0);
    cycle();
    check("first_write", 64'(pixelWrite), 64'd1);
    check("first_xy", 64'({xAddr, yAddr}), 64'd0);
    run_frame(NPIX + 50, 1'b0);

    // Single wall cell at the origin; neighbours are path, right of the maze is background.
    maze    = '0;
    maze[0] = 1'b1;
    add_spot(0, 0, 16'h0000);
    add_spot(8, 0, 16'h07E0);
    add_spot(32, 0, 16'h001F);
`ifdef MAZE_RENDER_GRID_EN
    add_spot(7, 7, 16'h8410);
`else
    add_spot(7, 7, 16'h0000);
`endif
    add_spot(0, 8, 16'h07E0);
    start_frame();
    run_frame(NPIX + 50, 1'b0);

    // Random maze with pixelReady high one cycle in three; start mid-frame must be ignored.
    maze = MB'({$urandom(), $urandom()});
    start_frame();
    run_frame(3 * NPIX + 100, 1'b1);

    // Maze regeneration mid-frame restarts from the origin without a frameDone.
    maze       = MB'({$urandom(), $urandom()});
    pixelReady = 1'b1;
    start_frame();
    n = 0;
    while (!(pixelWrite && xAddr == 8'd20 && yAddr == 9'd40) && n < NPIX) begin
      cycle();
      n++;
    end
    check("reached_drop_pixel", 64'({xAddr, yAddr}), 64'({8'd20, 9'd40}));
    mazeValid  = 1'b0;
    pixelReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("drop_write", 64'(pixelWrite), 64'd0);
      check("drop_busy", 64'(busy), 64'd1);
    end
    check("drop_xy", 64'({xAddr, yAddr}), 64'd0);
    push_frame();
    accepts    = 0;
    mazeValid  = 1'b1;
    pixelReady = 1'b1;
    run_frame(NPIX + 50, 1'b0);

    // Asynchronous reset mid-frame returns to reset values without waiting for an edge.
    start_frame();
    for (int i = 0; i < 30; i++) cycle();
    #2 globalReset = 1'b1;
    #1;
    check("arst_write", 64'(pixelWrite), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_xy", 64'({xAddr, yAddr}), 64'd0);
    check("arst_data", 64'(pixelData), 64'd0);
    sb.delete();
    spots.delete();
    cycle();
    globalReset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("post_rst_busy", 64'(busy), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
